// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer: FSM state encoding
// and the thermometer bank pattern.
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LEFT,
    RIGHT,
    HAZARD
  } tl_state_t;

  // Widest bank the pattern helper can describe; callers truncate to their width.
  localparam int MAX_LEDS = 32;

  // Thermometer fill from bit 0: the lowest `phase` bits are lit, capped at n.
  function automatic logic [MAX_LEDS-1:0] thermo(input int phase, input int n);
    logic [MAX_LEDS-1:0] pat;
    pat = '0;
    for (int i = 0; i < MAX_LEDS; i++) begin
      pat[i] = (i < phase) && (i < n);
    end
    return pat;
  endfunction

endpackage

// File: rtl/tl_step_timer.sv
// Free-running step divider: a one-cycle tick every TICK_DIV clocks, with a
// synchronous clear that restarts the count from zero.
module tl_step_timer #(
  parameter int TICK_DIV = 5_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tail_light_seq.sv
// Thunderbird-style tail-light sequencer: synchronised active-low buttons drive
// a LEFT/RIGHT sweep or HAZARD blink FSM, with a steady brake overlay.
module tail_light_seq
  import tail_light_pkg::*;
#(
  parameter int LEDS_PER_SIDE = 3,
  parameter int TICK_DIV      = 5_000_000
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     right_button,
  input  logic                     left_button,
  input  logic                     hazard_button,
  input  logic                     brake_button,
  output logic [LEDS_PER_SIDE-1:0] right_leds,
  output logic [LEDS_PER_SIDE-1:0] left_leds,
  output logic                     all_leds_on
);

  localparam int                       PW      = $clog2(LEDS_PER_SIDE + 1);
  localparam logic [PW-1:0]            LAST_PH = PW'(LEDS_PER_SIDE);
  localparam logic [PW-1:0]            FIRST_PH = PW'(1);
  localparam logic [LEDS_PER_SIDE-1:0] ONES    = '1;

  if (LEDS_PER_SIDE < 1 || LEDS_PER_SIDE > MAX_LEDS) begin : g_bad_leds
    $error("tail_light_seq: LEDS_PER_SIDE must be in 1..%0d", MAX_LEDS);
  end
  if (TICK_DIV < 2) begin : g_bad_div
    $error("tail_light_seq: TICK_DIV must be >= 2");
  end

  // Bits: {brake, hazard, left, right}, stored inverted so 0 means released.
  logic [3:0] sync1_q, sync2_q;

  // NOTE: flops reset to the released level so no request fires out of reset;
  // non-blocking assignment makes sync2_q take the previous sync1_q value.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= ~{brake_button, hazard_button, left_button, right_button};
      sync2_q <= sync1_q;
    end
  end

  logic req_r, req_l, req_h, brk, haz, any_req;
  assign {brk, req_h, req_l, req_r} = sync2_q;
  assign haz     = req_h | (req_l & req_r);
  assign any_req = haz | req_l | req_r;

  tl_state_t       state_q, state_d, entry_state;
  logic [PW-1:0]   phase_q, phase_d, entry_phase;
  logic            step_tick, timer_clear, sweeping;

  assign sweeping    = (state_q == LEFT) || (state_q == RIGHT);
  assign timer_clear = (state_q == IDLE) || (sweeping && haz);
  assign entry_state = haz ? HAZARD : req_l ? LEFT : req_r ? RIGHT : IDLE;
  assign entry_phase = any_req ? FIRST_PH : '0;

  tl_step_timer #(.TICK_DIV(TICK_DIV)) u_timer (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (timer_clear),
    .tick   (step_tick)
  );

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        state_d = entry_state;
        phase_d = entry_phase;
      end
      LEFT, RIGHT: begin
        if (haz) begin
          state_d = HAZARD;
          phase_d = FIRST_PH;
        end else if (step_tick) begin
          if (phase_q == '0) begin
            state_d = entry_state;
            phase_d = entry_phase;
          end else if (phase_q == LAST_PH) begin
            phase_d = '0;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
      end
      HAZARD: begin
        if (step_tick) begin
          if (phase_q == '0) begin
            state_d = entry_state;
            phase_d = entry_phase;
          end else begin
            phase_d = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  // Outputs are computed from the next state so they register on the same edge.
  logic [LEDS_PER_SIDE-1:0] active_pat, left_d, right_d, left_q, right_q;
  assign active_pat = LEDS_PER_SIDE'(thermo(int'(phase_d), LEDS_PER_SIDE));

  always_comb begin
    left_d  = '0;
    right_d = '0;
    unique case (state_d)
      IDLE: if (brk) begin
        left_d  = ONES;
        right_d = ONES;
      end
      LEFT: begin
        left_d = active_pat;
        if (brk) right_d = ONES;
      end
      RIGHT: begin
        right_d = active_pat;
        if (brk) left_d = ONES;
      end
      HAZARD: if (phase_d != '0) begin
        left_d  = ONES;
        right_d = ONES;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      left_q  <= '0;
      right_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      left_q  <= left_d;
      right_q <= right_d;
    end
  end

  assign left_leds   = left_q;
  assign right_leds  = right_q;
  assign all_leds_on = &{left_q, right_q};

endmodule
